elevator_timer: RTL

Programmable duration timer on the far end of the elevator controller's counter handshake. Receives the `counter_init` request pulse from the elevator FSM and, after a door-dwell or travel duration, returns a single-cycle `counter_done` pulse. It sits beside the elevator FSM in the elevator top level and replaces the abstract counter the FSM's assertions treat as an environment input.

---
 rtl/elevator_pkg.sv | 18 +
 rtl/elevator_prescaler.sv | 30 +++
 rtl/elevator_timer.sv | 99 +++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and default timing constants for the elevator timer.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } timer_state_e;

  localparam int DEF_PRESCALE     = 4;
  localparam int DEF_DWELL_TICKS  = 8;
  localparam int DEF_TRAVEL_TICKS = 12;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elevator_prescaler.sv
// Cycle prescaler: down-counter that wraps to PRESCALE-1; tick_o is high while it sits at 0.
module elevator_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic tick_o
);

  // A prescale of 1 still needs a 1-bit counter; it simply stays at 0.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] RELOAD = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (load_i || (en_i && tick_o)) begin
      cnt <= RELOAD;
    end else if (en_i) begin
      cnt <= cnt - PW'(1);
    end
  end

  assign tick_o = (cnt == '0);

endmodule

// File: rtl/elevator_timer.sv
// Door-dwell / travel duration timer answering the elevator FSM's counter_init with counter_done.
// Optional door-hold extension compiled in with ELEVATOR_TIMER_HOLD_EN.
//
// state | meaning
// IDLE  | waiting for counter_init
// COUNT | timing the selected duration
// DONE  | one-cycle expiry pulse
module elevator_timer
  import elevator_pkg::*;
#(
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int DWELL_TICKS  = DEF_DWELL_TICKS,
  parameter int TRAVEL_TICKS = DEF_TRAVEL_TICKS,
  parameter int CNT_W        = $clog2(max_int(DWELL_TICKS, TRAVEL_TICKS) + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             counter_init_i,
  input  logic             sel_travel_i,
  input  logic             hold_i,
  output logic             counter_done_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] remaining_o
);

  if (PRESCALE < 1 || DWELL_TICKS < 1 || TRAVEL_TICKS < 1) begin : g_param_check
    $error("elevator_timer: PRESCALE, DWELL_TICKS and TRAVEL_TICKS must all be >= 1");
  end

  localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_TICKS);
  localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_TICKS);

  timer_state_e     state, state_next;
  logic [CNT_W-1:0] tick_cnt;
  logic             mode_travel;
  logic             tick;
  logic             hold_reload;
  logic             expire;

`ifdef ELEVATOR_TIMER_HOLD_EN
  assign hold_reload = (state == COUNT) && hold_i && !mode_travel && !counter_init_i;
`else
  logic hold_unused;
  assign hold_reload = 1'b0;
  assign hold_unused = hold_i ^ mode_travel;
`endif

  assign expire = (state == COUNT) && tick && (tick_cnt == CNT_W'(1));

  elevator_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (counter_init_i || hold_reload),
    .en_i   (state == COUNT),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Restart and hold both override expiry on the same edge.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = IDLE;
      COUNT:   if (expire) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (hold_reload)    state_next = COUNT;
    if (counter_init_i) state_next = COUNT;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tick_cnt    <= '0;
      mode_travel <= 1'b0;
    end else if (counter_init_i) begin
      tick_cnt    <= sel_travel_i ? TRAVEL_LOAD : DWELL_LOAD;
      mode_travel <= sel_travel_i;
    end else if (hold_reload) begin
      tick_cnt <= DWELL_LOAD;
    end else if ((state == COUNT) && tick) begin
      tick_cnt <= tick_cnt - CNT_W'(1);
    end
  end

  assign counter_done_o = (state == DONE);
  assign busy_o         = (state == COUNT);
  assign remaining_o    = (state == COUNT) ? tick_cnt : '0;

endmodule
